// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-input round-robin stream multiplexer.
package stream_mux_pkg;
  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Select width for n channels, never narrower than one bit
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational N-way arbiter: round-robin from ptr or fixed lowest-index priority,
// forced to lock_ch while a packet is in flight.
module rr_arbiter_n
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int MODE = MODE_RR,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            lock,
  input  logic [SELW-1:0] lock_ch,
  output logic [SELW-1:0] grant,
  output logic            grant_vld
);

  logic [SELW-1:0] idx;

  // Scans run from the lowest-priority candidate upward so the last hit wins
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    if (lock) begin
      grant     = lock_ch;
      grant_vld = req[lock_ch];
    end else if (MODE == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[SELW'(i)]) begin
          grant     = SELW'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = SELW'((int'(ptr) + k) % N);
        if (req[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_muxn_rr.sv
// N-input valid/ready stream mux with packet-locked arbitration and a registered
// output stage that sustains one beat per cycle.
module stream_muxn_rr
  import stream_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = MODE_RR,
  localparam int SELW  = sel_width(N)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr, lock_ch, grant, ptr_nxt;
  logic             locked, grant_vld, load_en, xfer, sel_last;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter_n #(.N(N), .MODE(MODE)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .lock      (locked),
    .lock_ch   (lock_ch),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  assign load_en  = ~out_valid | out_ready;
  assign sel_data = in_data[grant*WIDTH +: WIDTH];
  assign sel_last = in_last[grant];
  assign xfer     = |(in_valid & in_ready);
  assign ptr_nxt  = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    in_ready = '0;
    if (load_en && grant_vld && !RESET) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
      locked    <= 1'b0;
      lock_ch   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_sel   <= grant;
      // End of packet releases the lock; only then does round-robin advance
      if (sel_last) begin
        locked <= 1'b0;
        if (MODE == MODE_RR) ptr <= ptr_nxt;
      end else begin
        locked  <= 1'b1;
        lock_ch <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_muxn_rr.sv
// Directed bench for stream_muxn_rr: a round-robin and a fixed-priority instance
// share the same stimulus.
module tb_stream_muxn_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic           CLK, RESET, out_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last;

  logic [N-1:0] rr_in_ready, fp_in_ready;
  logic [W-1:0] rr_data, fp_data;
  logic         rr_valid, fp_valid, rr_last, fp_last;
  logic [1:0]   rr_sel, fp_sel;

  int errors = 0;
  int checks = 0;

  stream_muxn_rr #(.N(N), .WIDTH(W), .MODE(0)) dut_rr (
    .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rr_in_ready), .out_data(rr_data), .out_valid(rr_valid), .out_last(rr_last),
    .out_sel(rr_sel), .out_ready(out_ready)
  );

  stream_muxn_rr #(.N(N), .WIDTH(W), .MODE(1)) dut_fp (
    .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(fp_in_ready), .out_data(fp_data), .out_valid(fp_valid), .out_last(fp_last),
    .out_sel(fp_sel), .out_ready(out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_sel [5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset with every channel requesting
    RESET     = 1'b1;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_in_ready", 32'(rr_in_ready), 32'h0);
      check("rst_fp_in_ready", 32'(fp_in_ready), 32'h0);
      check("rst_out_valid", 32'(rr_valid), 32'h0);
      check("rst_out_sel", 32'(rr_sel), 32'h0);
    end
    check("rst_out_data", 32'(rr_data), 32'h0);

    // Round-robin fairness, single-beat packets
    RESET = 1'b0;
    #1;
    check("rr_first_ready", 32'(rr_in_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_sel", 32'(rr_sel), 32'(exp_sel[k]));
      check("rr_valid", 32'(rr_valid), 32'h1);
      check("rr_data", 32'(rr_data), 32'(8'hA0 + 8'(exp_sel[k])));
    end

    // Packet lock on ch1 (ptr now 1) while ch0/ch2 also request
    in_valid      = 4'b0111;
    in_last       = 4'b0101;
    in_data[15:8] = 8'h11;
    #1;
    check("lock_ready_b1", 32'(rr_in_ready), 32'b0010);
    tick();
    check("lock_sel_b1", 32'(rr_sel), 32'd1);
    check("lock_data_b1", 32'(rr_data), 32'h11);
    check("lock_last_b1", 32'(rr_last), 32'h0);
    in_data[15:8] = 8'h12;
    tick();
    check("lock_sel_b2", 32'(rr_sel), 32'd1);
    check("lock_data_b2", 32'(rr_data), 32'h12);
    in_valid = 4'b0101;
    #1;
    check("lock_stall_ready", 32'(rr_in_ready), 32'h0);
    tick();
    check("lock_gap1_valid", 32'(rr_valid), 32'h0);
    check("lock_gap1_ready", 32'(rr_in_ready), 32'h0);
    tick();
    check("lock_gap2_valid", 32'(rr_valid), 32'h0);
    in_valid      = 4'b0111;
    in_last       = 4'b0111;
    in_data[15:8] = 8'h13;
    #1;
    check("lock_ready_b3", 32'(rr_in_ready), 32'b0010);
    tick();
    check("lock_sel_b3", 32'(rr_sel), 32'd1);
    check("lock_data_b3", 32'(rr_data), 32'h13);
    check("lock_last_b3", 32'(rr_last), 32'h1);
    check("unlock_ready_ch2", 32'(rr_in_ready), 32'b0100);
    tick();
    check("after_lock_sel2", 32'(rr_sel), 32'd2);
    check("after_lock_data2", 32'(rr_data), 32'hA2);
    tick();
    check("after_lock_sel0", 32'(rr_sel), 32'd0);

    // Backpressure: output must freeze and no channel may be accepted
    out_ready = 1'b0;
    #1;
    check("bp_ready_now", 32'(rr_in_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid", 32'(rr_valid), 32'h1);
      check("bp_sel", 32'(rr_sel), 32'd0);
      check("bp_data", 32'(rr_data), 32'hA0);
      check("bp_ready", 32'(rr_in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(rr_in_ready), 32'b0010);
    tick();
    check("bp_release_sel", 32'(rr_sel), 32'd1);
    check("bp_release_valid", 32'(rr_valid), 32'h1);
    check("bp_release_data", 32'(rr_data), 32'h13);

    // Fixed priority: ch3 starves behind ch0
    in_valid = 4'b1001;
    in_last  = 4'hF;
    #1;
    check("fp_ready", 32'(fp_in_ready), 32'b0001);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("fp_sel", 32'(fp_sel), 32'd0);
      check("fp_valid", 32'(fp_valid), 32'h1);
      check("fp_ready_hold", 32'(fp_in_ready), 32'b0001);
    end

    // Reset in the middle of a ch2 packet
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    tick();
    check("mid_sel", 32'(rr_sel), 32'd2);
    check("mid_last", 32'(rr_last), 32'h0);
    in_valid = 4'b0101;
    RESET    = 1'b1;
    #1;
    check("mid_rst_ready", 32'(rr_in_ready), 32'h0);
    tick();
    check("mid_rst_valid", 32'(rr_valid), 32'h0);
    check("mid_rst_sel", 32'(rr_sel), 32'd0);
    RESET = 1'b0;
    #1;
    check("post_rst_ready", 32'(rr_in_ready), 32'b0001);
    tick();
    check("post_rst_sel", 32'(rr_sel), 32'd0);
    check("post_rst_valid", 32'(rr_valid), 32'h1);
    check("post_rst_data", 32'(rr_data), 32'hA0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
